stream_drain_arb: RTL and testbench
===================================

# stream_drain_arb

Shared discard sink for valid/ready streams that have no consumer. Up to NumIn requesters present beats; the block grants one per accepted beat using round-robin arbitration. It throws the data away, can insert a programmable idle gap after every beat, and keeps saturating per-port and total discard counters for debug. It sits in the common-cells layer next to tie-off and sink helpers. It is instantiated wherever a subsystem must keep a handshake alive without dropping protocol.

## Interface
- NumIn, 4: number of requesters, ≥1
- DataWidth, 32: beat width; data is accepted and ignored
- CntWidth, 16: width of each discard counter
- GapWidth, 4: width of the gap setting
- IdxWidth, max(1, $clog2(NumIn)): derived, not overridable

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- en_i  in  1  drain enable; low forces all ready low
- gap_i  in  GapWidth  idle cycles inserted after each accepted beat
- clr_i  in  1  synchronous clear of all counters
- inp_valid_i  in  NumIn  per-port valid
- inp_data_i  in  NumIn*DataWidth  per-port data, discarded
- inp_ready_o  out  NumIn  per-port ready, at most one bit set
- drop_o  out  1  pulses in the cycle a beat is accepted
- drop_idx_o  out  IdxWidth  port accepted this cycle; valid only with drop_o
- port_cnt_o  out  NumIn*CntWidth  per-port discarded-beat counters
- total_cnt_o  out  CntWidth  discarded beats summed over all ports
- busy_o  out  1  high while in GAP

## Operation
- FSM states:
  - IDLE: grant is enabled.
  - GAP: gap countdown runs; all ready outputs are low.
- Grant in IDLE:
  - Condition: en_i=1 and at least one valid.
  - The selected port is the first port with valid=1, searching from rr_ptr upward with wrap-around.
  - inp_ready_o[sel]=1 combinationally; the beat is accepted in that cycle.
  - drop_o=1 and drop_idx_o=sel.
- Pointer update: rr_ptr ← (sel+1) mod NumIn on accept only. It is unchanged in idle cycles.
- Gap handling:
  - On accept with gap_i=0, the FSM stays in IDLE.
  - On accept with gap_i≠0, the FSM goes to GAP with gap_cnt ← gap_i.
  - In GAP, gap_cnt decrements each cycle.
  - When gap_cnt=1, the FSM returns to IDLE on the next edge. GAP therefore lasts exactly gap_i cycles.
  - gap_i is sampled only at accept; later changes do not affect the running gap.
- en_i:
  - en_i=0 in IDLE: no grant.
  - en_i=0 in GAP: the countdown continues.
  - en_i has no effect on the counters or clr_i.
- Counters:
  - On accept, port_cnt[sel] and total_cnt each increment by 1.
  - Each counter saturates at 2^CntWidth−1 and holds there.
  - clr_i=1 zeroes all counters.
  - clr_i and accept in the same cycle: the counters become 0, except port_cnt[sel]=1 and total_cnt=1. The beat is never lost.
- Valid dropping before grant is tolerated: there is no stall, and it is not an error.
- NumIn=1: rr_ptr is constant 0 and drop_idx_o=0.
- Reset (rst_ni low, any time including mid-GAP) sets:
  - state=IDLE, rr_ptr=0, gap_cnt=0
  - all counters 0
  - inp_ready_o=0, drop_o=0, busy_o=0
  - After release, port 0 has first priority.

## Timing
- Ready, drop_o and drop_idx_o are combinational from inp_valid_i, en_i, state and rr_ptr.
- There is no path from inp_data_i to any output.
- Counters are registered: they update on the edge after accept, visible one cycle later.
- Throughput is 1 beat/cycle when gap_i=0. Otherwise it is 1 beat per (gap_i+1) cycles.
- busy_o is registered and equals (state==GAP).

## Test plan
- Reset then all 4 valid, gap_i=0, en_i=1:
  - Grants are 0,1,2,3,0,… on consecutive cycles.
  - After 8 cycles, each port_cnt=2 and total_cnt=8.
- Only port 2 valid, gap_i=3:
  - Accepts occur at cycles 0, 4, 8.
  - busy_o is high for cycles 1–3 and 5–7.
  - ready is low on every port during GAP.
- en_i=0 with all valid for 5 cycles:
  - No ready, no drop_o, counters unchanged.
  - Raise en_i: port rr_ptr is granted the same cycle.
- CntWidth=4, port 1 streams 20 beats:
  - port_cnt[1] holds 15 and total_cnt holds 15.
  - Assert clr_i on an accept cycle: port_cnt[1]=1 and total_cnt=1 next cycle.
- Drop rst_ni mid-GAP (gap_i=7, 3 cycles in):
  - Outputs go to their reset values immediately.
  - After release, valid on ports 0 and 3 grants port 0 first.
- Port 3 granted, then only ports 0 and 3 valid:
  - Port 0 is granted next (wrap), then port 3.

Source files
------------

// File: rtl/stream_drain_arb.sv
// Round-robin discard sink: accepts one beat per grant from up to NumIn streams,
// optionally idles for a programmable gap, and keeps saturating drop counters.
module stream_drain_arb #(
    parameter int unsigned NumIn     = 4,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned CntWidth  = 16,
    parameter int unsigned GapWidth  = 4,
    localparam int unsigned IdxWidth = (NumIn > 1) ? $clog2(NumIn) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          en_i,
    input  logic [GapWidth-1:0]           gap_i,
    input  logic                          clr_i,
    input  logic [NumIn-1:0]              inp_valid_i,
    input  logic [NumIn*DataWidth-1:0]    inp_data_i,
    output logic [NumIn-1:0]              inp_ready_o,
    output logic                          drop_o,
    output logic [IdxWidth-1:0]           drop_idx_o,
    output logic [NumIn*CntWidth-1:0]     port_cnt_o,
    output logic [CntWidth-1:0]           total_cnt_o,
    output logic                          busy_o
);

    typedef enum logic {IDLE, GAP} state_e;

    state_e                state_q, state_d;
    logic [IdxWidth-1:0]   rr_q, rr_d;
    logic [GapWidth-1:0]   gap_q, gap_d;
    logic [CntWidth-1:0]   port_cnt_q [NumIn];
    logic [CntWidth-1:0]   port_cnt_d [NumIn];
    logic [CntWidth-1:0]   total_q, total_d;

    logic [IdxWidth-1:0]   sel;
    logic                  found;
    logic                  grant;
    logic [NumIn-1:0]      acc_vec;

    // Data is intentionally dropped; this only keeps the input referenced.
    logic unused_data;
    assign unused_data = ^inp_data_i;

    // First valid port at or above rr_q, wrapping around.
    always_comb begin
        int unsigned p;
        sel   = '0;
        found = 1'b0;
        p     = 0;
        for (int unsigned k = 0; k < NumIn; k++) begin
            p = (32'(rr_q) + k) % NumIn;
            if (!found && inp_valid_i[p]) begin
                found = 1'b1;
                sel   = IdxWidth'(p);
            end
        end
    end

    // Reset also masks the combinational handshake so nothing is granted while held.
    assign grant = rst_ni && en_i && (state_q == IDLE) && found;

    generate
        for (genvar gi = 0; gi < NumIn; gi++) begin : g_port
            assign acc_vec[gi] = grant && (sel == IdxWidth'(gi));
            assign port_cnt_o[gi*CntWidth +: CntWidth] = port_cnt_q[gi];
        end
    endgenerate

    assign inp_ready_o = acc_vec;
    assign drop_o      = grant;
    assign drop_idx_o  = grant ? sel : '0;
    assign total_cnt_o = total_q;
    assign busy_o      = (state_q == GAP);

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        rr_d    = rr_q;
        if (grant) begin
            rr_d = (sel == IdxWidth'(NumIn - 1)) ? '0 : sel + 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (grant && (gap_i != '0)) begin
                    state_d = GAP;
                    gap_d   = gap_i;
                end
            end
            GAP: begin
                if (gap_q == GapWidth'(1)) begin
                    state_d = IDLE;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gap_d   = '0;
            end
        endcase
    end

    // Clear wins over history, but a beat accepted alongside the clear still counts.
    always_comb begin
        for (int i = 0; i < NumIn; i++) begin
            port_cnt_d[i] = port_cnt_q[i];
            if (clr_i) begin
                port_cnt_d[i] = acc_vec[i] ? CntWidth'(1) : '0;
            end else if (acc_vec[i] && (port_cnt_q[i] != '1)) begin
                port_cnt_d[i] = port_cnt_q[i] + 1'b1;
            end
        end
        total_d = total_q;
        if (clr_i) begin
            total_d = grant ? CntWidth'(1) : '0;
        end else if (grant && (total_q != '1)) begin
            total_d = total_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rr_q    <= '0;
            gap_q   <= '0;
            total_q <= '0;
            for (int i = 0; i < NumIn; i++) begin
                port_cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gap_q   <= gap_d;
            total_q <= total_d;
            for (int i = 0; i < NumIn; i++) begin
                port_cnt_q[i] <= port_cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_stream_drain_arb.sv
// Randomized scoreboard bench for stream_drain_arb against a cycle-level
// reference model built from the arbitration, gap and counter rules.
module tb_stream_drain_arb;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int CW = 4;
    localparam int GW = 4;
    localparam int SAT = (1 << CW) - 1;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b1;
    logic            en_i = 1'b0;
    logic [GW-1:0]   gap_i = '0;
    logic            clr_i = 1'b0;
    logic [N-1:0]    inp_valid_i = '0;
    logic [N*DW-1:0] inp_data_i = '0;
    logic [N-1:0]    inp_ready_o;
    logic            drop_o;
    logic [1:0]      drop_idx_o;
    logic [N*CW-1:0] port_cnt_o;
    logic [CW-1:0]   total_cnt_o;
    logic            busy_o;

    stream_drain_arb #(
        .NumIn(N), .DataWidth(DW), .CntWidth(CW), .GapWidth(GW)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .gap_i(gap_i), .clr_i(clr_i),
        .inp_valid_i(inp_valid_i), .inp_data_i(inp_data_i), .inp_ready_o(inp_ready_o),
        .drop_o(drop_o), .drop_idx_o(drop_idx_o), .port_cnt_o(port_cnt_o),
        .total_cnt_o(total_cnt_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [N-1:0]    ready;
        logic            drop;
        logic [1:0]      idx;
        logic            busy;
        logic [N*CW-1:0] cnt;
        logic [CW-1:0]   total;
    } exp_t;

    exp_t expq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference state: round-robin start port, remaining blocked cycles, counts.
    int m_rr = 0;
    int m_gap = 0;
    int m_cnt[N];
    int m_total = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int sat_inc(int v);
        return (v >= SAT) ? SAT : v + 1;
    endfunction

    task automatic model_reset();
        m_rr = 0;
        m_gap = 0;
        m_total = 0;
        for (int p = 0; p < N; p++) m_cnt[p] = 0;
    endtask

    // Apply this cycle's inputs, record what the DUT must show, then advance the model.
    task automatic drive(input logic [N-1:0] v, input logic e, input logic [GW-1:0] g, input logic c);
        exp_t x;
        int   sel;
        inp_valid_i = v;
        en_i        = e;
        gap_i       = g;
        clr_i       = c;
        inp_data_i  = {$urandom, $urandom, $urandom, $urandom};
        x = '0;
        sel = -1;
        x.busy = (m_gap > 0);
        for (int p = 0; p < N; p++) x.cnt[p*CW +: CW] = CW'(m_cnt[p]);
        x.total = CW'(m_total);
        if (m_gap == 0 && e && v != '0) begin
            for (int k = 0; k < N; k++) begin
                if (sel < 0 && v[(m_rr + k) % N]) sel = (m_rr + k) % N;
            end
            x.drop = 1'b1;
            x.idx = 2'(sel);
            x.ready[sel] = 1'b1;
        end
        expq.push_back(x);
        if (c) begin
            for (int p = 0; p < N; p++) m_cnt[p] = 0;
            m_total = 0;
        end
        if (sel >= 0) begin
            m_cnt[sel] = sat_inc(m_cnt[sel]);
            m_total = sat_inc(m_total);
            m_rr = (sel + 1) % N;
            m_gap = int'(g);
        end else if (m_gap > 0) begin
            m_gap--;
        end
    endtask

    task automatic step(input logic [N-1:0] v, input logic e, input logic [GW-1:0] g, input logic c);
        @(posedge clk_i);
        #1;
        drive(v, e, g, c);
    endtask

    // Called 1 time unit after a rising edge; returns 1 unit after the next one with reset released.
    task automatic reset_pulse(input logic [N-1:0] v);
        exp_t x;
        inp_valid_i = v;
        en_i = 1'b1;
        gap_i = '0;
        clr_i = 1'b0;
        #1 rst_ni = 1'b0;
        #1;
        chk("rst_ready", 32'(inp_ready_o), 32'h0);
        chk("rst_drop", 32'(drop_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        x = '0;
        expq.push_back(x);
        model_reset();
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
    endtask

    always @(negedge clk_i) begin
        if (expq.size() > 0) begin
            exp_t x;
            x = expq.pop_front();
            chk("ready", 32'(inp_ready_o), 32'(x.ready));
            chk("drop", 32'(drop_o), 32'(x.drop));
            if (x.drop) chk("drop_idx", 32'(drop_idx_o), 32'(x.idx));
            chk("busy", 32'(busy_o), 32'(x.busy));
            chk("port_cnt", 32'(port_cnt_o), 32'(x.cnt));
            chk("total_cnt", 32'(total_cnt_o), 32'(x.total));
            if (drop_o) $display("[TB] t=%0t beat dropped from port %0d", $time, drop_idx_o);
        end
    end

    initial begin
        model_reset();
        @(posedge clk_i);
        #1;
        reset_pulse(4'b1111);
        // All ports valid, no gap: strict 0,1,2,3 rotation.
        drive(4'b1111, 1'b1, 4'd0, 1'b0);
        repeat (8) step(4'b1111, 1'b1, 4'd0, 1'b0);
        // Single port with gap of 3.
        repeat (10) step(4'b0100, 1'b1, 4'd3, 1'b0);
        // Enable low, then raised.
        repeat (5) step(4'b1111, 1'b0, 4'd0, 1'b0);
        step(4'b1111, 1'b1, 4'd0, 1'b0);
        // Port 1 streams into saturation, then clear on an accept.
        repeat (20) step(4'b0010, 1'b1, 4'd0, 1'b0);
        step(4'b0010, 1'b1, 4'd0, 1'b1);
        step(4'b0000, 1'b1, 4'd0, 1'b0);
        step(4'b0000, 1'b1, 4'd0, 1'b1);
        // Reset three cycles into a 7-cycle gap; port 0 must win afterwards.
        step(4'b0100, 1'b1, 4'd7, 1'b0);
        repeat (3) step(4'b1111, 1'b1, 4'd0, 1'b0);
        @(posedge clk_i);
        #1;
        reset_pulse(4'b1001);
        drive(4'b1001, 1'b1, 4'd0, 1'b0);
        step(4'b1001, 1'b1, 4'd0, 1'b0);
        // Wrap from port 3 back to port 0.
        step(4'b1000, 1'b1, 4'd0, 1'b0);
        step(4'b1001, 1'b1, 4'd0, 1'b0);
        step(4'b1001, 1'b1, 4'd0, 1'b0);
        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            logic [GW-1:0] g;
            g = ($urandom_range(0, 3) == 0) ? GW'($urandom_range(1, 15)) : '0;
            step(N'($urandom_range(0, 15)), ($urandom_range(0, 9) != 0), g,
                 ($urandom_range(0, 49) == 0));
        end
        @(posedge clk_i);
        #1;
        inp_valid_i = '0;
        @(negedge clk_i);
        #1;
        chk("queue_drained", 32'(expq.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
